// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer for a MIPS datapath: owns the PC, fetches over a
// req/ack handshake, latches the IR and steps the datapath through EXEC/MEM/WB/BRANCH.
module mips_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        run,
  output logic        fetch_req,
  output logic [31:0] pc,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] INST,
  output logic        regDst,
  output logic        regWrite,
  output logic        ALUSrc,
  output logic        memWrite,
  output logic        memRead,
  output logic        memtoReg,
  output logic [3:0]  ALUcontrol,
  input  logic        is_Zero,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, BRANCH} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t      state;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        dec_valid;
  logic        dec_jump;
  logic [3:0]  dec_alu;
  logic        dec_src;
  logic        dec_dst;
  logic        dec_mtr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign opcode        = INST[31:26];
  assign funct         = INST[5:0];
  assign branch_taken  = (opcode == OP_BEQ) ? is_Zero : !is_Zero;
  assign branch_target = pc_plus4 + {{14{INST[15]}}, INST[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], INST[25:0], 2'b00};

  // Decode of the latched IR; only consumed while in DECODE.
  always_comb begin
    dec_valid = 1'b1;
    dec_jump  = 1'b0;
    dec_alu   = 4'b0010;
    dec_src   = 1'b0;
    dec_dst   = 1'b0;
    dec_mtr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_dst = 1'b1;
        case (funct)
          6'h20:   dec_alu = 4'b0010;
          6'h22:   dec_alu = 4'b0110;
          6'h24:   dec_alu = 4'b0000;
          6'h25:   dec_alu = 4'b0001;
          6'h2A:   dec_alu = 4'b0111;
          default: dec_valid = 1'b0;
        endcase
      end
      OP_LW: begin
        dec_src = 1'b1;
        dec_mtr = 1'b1;
      end
      OP_SW, OP_ADDI: dec_src = 1'b1;
      OP_BEQ, OP_BNE: dec_alu = 4'b0110;
      OP_J:           dec_jump = 1'b1;
      default:        dec_valid = 1'b0;
    endcase
  end

  // Every path back to FETCH re-arms fetch_req from run, so a new request
  // is visible in the very first FETCH cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pc_plus4   <= 32'h0;
      INST       <= 32'h0;
      retired    <= 32'h0;
      fetch_req  <= 1'b0;
      regDst     <= 1'b0;
      regWrite   <= 1'b0;
      ALUSrc     <= 1'b0;
      memWrite   <= 1'b0;
      memRead    <= 1'b0;
      memtoReg   <= 1'b0;
      ALUcontrol <= 4'b0000;
      illegal    <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        FETCH: begin
          if (fetch_req && fetch_ack) begin
            INST      <= fetch_data;
            pc_plus4  <= pc + 32'd4;
            fetch_req <= 1'b0;
            state     <= DECODE;
          end else begin
            fetch_req <= run;
          end
        end
        DECODE: begin
          if (dec_jump) begin
            pc        <= jump_target;
            retired   <= retired + 32'd1;
            fetch_req <= run;
            state     <= FETCH;
          end else if (dec_valid) begin
            ALUcontrol <= dec_alu;
            ALUSrc     <= dec_src;
            regDst     <= dec_dst;
            memtoReg   <= dec_mtr;
            state      <= EXEC;
          end else begin
            illegal   <= 1'b1;
            pc        <= pc_plus4;
            retired   <= retired + 32'd1;
            fetch_req <= run;
            state     <= FETCH;
          end
        end
        EXEC: begin
          if (opcode == OP_LW || opcode == OP_SW) begin
            memRead  <= (opcode == OP_LW);
            memWrite <= (opcode == OP_SW);
            state    <= MEM;
          end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
            state <= BRANCH;
          end else begin
            regWrite <= 1'b1;
            state    <= WB;
          end
        end
        MEM: begin
          if (opcode == OP_LW) begin
            regWrite <= 1'b1;
            state    <= WB;
          end else begin
            memWrite  <= 1'b0;
            pc        <= pc_plus4;
            retired   <= retired + 32'd1;
            fetch_req <= run;
            state     <= FETCH;
          end
        end
        WB: begin
          regWrite  <= 1'b0;
          memRead   <= 1'b0;
          pc        <= pc_plus4;
          retired   <= retired + 32'd1;
          fetch_req <= run;
          state     <= FETCH;
        end
        BRANCH: begin
          pc        <= branch_taken ? branch_target : pc_plus4;
          retired   <= retired + 32'd1;
          fetch_req <= run;
          state     <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: acts as instruction memory and datapath,
// comparing against an instruction-level model of pc, retire count, strobes and timing.
module tb_mips_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        run;
  logic        fetch_req;
  logic [31:0] pc;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic [31:0] INST;
  logic        regDst, regWrite, ALUSrc, memWrite, memRead, memtoReg;
  logic [3:0]  ALUcontrol;
  logic        is_Zero;
  logic        illegal;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_retired;

  typedef struct packed {
    int          cycles;
    int          n_rw;
    int          n_mw;
    int          n_mr;
    int          n_ill;
    logic [31:0] next_pc;
    logic        has_exec;
    logic [3:0]  alu;
    logic        alusrc;
    logic        dst_chk;
    logic        dst;
    logic        mtr;
  } exp_t;

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .CLK(CLK), .RST_N(RST_N), .run(run), .fetch_req(fetch_req), .pc(pc),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data), .INST(INST),
    .regDst(regDst), .regWrite(regWrite), .ALUSrc(ALUSrc), .memWrite(memWrite),
    .memRead(memRead), .memtoReg(memtoReg), .ALUcontrol(ALUcontrol),
    .is_Zero(is_Zero), .illegal(illegal), .retired(retired)
  );

  // Instruction-level semantics: what one instruction should do and how long it takes.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc_now, input bit equal);
    exp_t e;
    logic [31:0] pc4;
    int simm;
    bit taken;
    pc4 = pc_now + 32'd4;
    simm = int'($signed(ins[15:0]));
    e = '0;
    e.next_pc = pc4;
    e.cycles = 2;
    case (ins[31:26])
      6'h00: begin
        e.has_exec = 1'b1;
        case (ins[5:0])
          6'h20: e.alu = 4'b0010;
          6'h22: e.alu = 4'b0110;
          6'h24: e.alu = 4'b0000;
          6'h25: e.alu = 4'b0001;
          6'h2A: e.alu = 4'b0111;
          default: e.has_exec = 1'b0;
        endcase
        if (e.has_exec) begin
          e.cycles = 4; e.n_rw = 1; e.dst_chk = 1'b1; e.dst = 1'b1;
        end else begin
          e.n_ill = 1;
        end
      end
      6'h23: begin
        e.cycles = 5; e.n_rw = 1; e.n_mr = 2; e.has_exec = 1'b1; e.alu = 4'b0010;
        e.alusrc = 1'b1; e.dst_chk = 1'b1; e.mtr = 1'b1;
      end
      6'h2B: begin
        e.cycles = 4; e.n_mw = 1; e.has_exec = 1'b1; e.alu = 4'b0010;
        e.alusrc = 1'b1; e.dst_chk = 1'b1;
      end
      6'h08: begin
        e.cycles = 4; e.n_rw = 1; e.has_exec = 1'b1; e.alu = 4'b0010;
        e.alusrc = 1'b1; e.dst_chk = 1'b1;
      end
      6'h04, 6'h05: begin
        e.cycles = 4; e.has_exec = 1'b1; e.alu = 4'b0110;
        taken = (ins[31:26] == 6'h04) ? equal : !equal;
        if (taken) e.next_pc = pc4 + 32'(simm * 4);
      end
      6'h02: e.next_pc = {pc4[31:28], ins[25:0], 2'b00};
      default: e.n_ill = 1;
    endcase
    return e;
  endfunction

  task automatic wait_fetch_req(input string name, output bit ok);
    int budget;
    budget = 0;
    while (fetch_req !== 1'b1 && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    checks++;
    ok = (fetch_req === 1'b1);
    if (!ok) begin
      errors++;
      $display("FAIL %s fetch_req wait: got %b want 1", name, fetch_req);
    end
  endtask

  // Acts as imem + datapath for one instruction; is_Zero carries the wrong
  // value until the edge that ends EXEC, mimicking the datapath's late flag.
  task automatic run_instr(input logic [31:0] ins, input int delay, input bit equal, input string name);
    exp_t e;
    bit ok;
    int n, c_rw, c_mw, c_mr, c_ill, rw_at;
    e = model(ins, m_pc, equal);
    wait_fetch_req(name, ok);
    if (!ok) return;
    checks++;
    if (pc !== m_pc) begin
      errors++;
      $display("FAIL %s fetch pc: got %h want %h", name, pc, m_pc);
    end
    for (int d = 0; d < delay; d++) begin
      fetch_ack = 1'b0;
      @(negedge CLK);
      checks++;
      if (fetch_req !== 1'b1 || pc !== m_pc) begin
        errors++;
        $display("FAIL %s hold: got req=%b pc=%h want req=1 pc=%h", name, fetch_req, pc, m_pc);
      end
    end
    fetch_ack = 1'b1;
    fetch_data = ins;
    is_Zero = !equal;
    @(negedge CLK);
    fetch_ack = 1'b0;
    fetch_data = $urandom;
    n = 1; c_rw = 0; c_mw = 0; c_mr = 0; c_ill = 0; rw_at = 0;
    while (n < 12) begin
      if (regWrite === 1'b1) begin c_rw++; rw_at = n; end
      if (memWrite === 1'b1) c_mw++;
      if (memRead === 1'b1) begin
        c_mr++;
        checks++;
        if (memtoReg !== 1'b1) begin
          errors++;
          $display("FAIL %s memtoReg during read: got %b want 1", name, memtoReg);
        end
      end
      if (illegal === 1'b1) c_ill++;
      if (n == 2 && e.has_exec) begin
        checks++;
        if (ALUcontrol !== e.alu || ALUSrc !== e.alusrc ||
            (e.dst_chk && (regDst !== e.dst || memtoReg !== e.mtr))) begin
          errors++;
          $display("FAIL %s exec controls: got alu=%b src=%b dst=%b mtr=%b want alu=%b src=%b dst=%b mtr=%b",
                   name, ALUcontrol, ALUSrc, regDst, memtoReg, e.alu, e.alusrc, e.dst, e.mtr);
        end
      end
      if (fetch_req === 1'b1) break;
      is_Zero = (n >= 2) ? equal : !equal;
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n != e.cycles) begin
      errors++;
      $display("FAIL %s cycles: got %0d want %0d", name, n + delay, e.cycles + delay);
    end
    checks++;
    if (c_rw != e.n_rw || c_mw != e.n_mw || c_mr != e.n_mr || c_ill != e.n_ill) begin
      errors++;
      $display("FAIL %s strobes: got rw=%0d mw=%0d mr=%0d ill=%0d want rw=%0d mw=%0d mr=%0d ill=%0d",
               name, c_rw, c_mw, c_mr, c_ill, e.n_rw, e.n_mw, e.n_mr, e.n_ill);
    end
    if (e.n_rw == 1) begin
      checks++;
      if (rw_at != e.cycles - 1) begin
        errors++;
        $display("FAIL %s regWrite cycle: got %0d want %0d", name, rw_at + 1, e.cycles);
      end
    end
    checks++;
    if (pc !== e.next_pc || retired !== m_retired + 32'd1) begin
      errors++;
      $display("FAIL %s next pc/retired: got %h/%0d want %h/%0d", name, pc, retired, e.next_pc, m_retired + 32'd1);
    end
    m_pc = e.next_pc;
    m_retired = m_retired + 32'd1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; run = 1'b1; fetch_ack = 1'b0; fetch_data = 32'h0; is_Zero = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (fetch_req !== 1'b0 || pc !== 32'h100 || retired !== 32'h0 || INST !== 32'h0) begin
      errors++;
      $display("FAIL reset state: got req=%b pc=%h ret=%0d inst=%h want 0/100/0/0", fetch_req, pc, retired, INST);
    end
    checks++;
    if ({regWrite, memWrite, memRead, illegal, regDst, ALUSrc, memtoReg} !== 7'b0 || ALUcontrol !== 4'b0) begin
      errors++;
      $display("FAIL reset controls: got strobes=%b alu=%b want all 0",
               {regWrite, memWrite, memRead, illegal, regDst, ALUSrc, memtoReg}, ALUcontrol);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (fetch_req !== 1'b1 || pc !== 32'h100) begin
      errors++;
      $display("FAIL reset release: got req=%b pc=%h want 1/100", fetch_req, pc);
    end
    m_pc = 32'h100;
    m_retired = 32'h0;
  endtask

  task automatic test_add;
    run_instr(32'h0022_1820, 0, 1'b0, "add");
    checks++;
    if (pc !== 32'h104 || retired !== 32'd1) begin
      errors++;
      $display("FAIL add result: got pc=%h ret=%0d want 104/1", pc, retired);
    end
  endtask

  task automatic test_lw_sw;
    run_instr({6'h23, 5'd1, 5'd2, 16'h0010}, 3, 1'b0, "lw");
    run_instr({6'h2B, 5'd1, 5'd2, 16'h0014}, 3, 1'b0, "sw");
  endtask

  task automatic test_branch;
    run_instr({6'h02, 26'h80}, 0, 1'b0, "j_to_200");
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFF}, 0, 1'b1, "beq_eq");
    checks++;
    if (pc !== 32'h200) begin
      errors++;
      $display("FAIL beq taken pc: got %h want 200", pc);
    end
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFF}, 1, 1'b0, "beq_ne");
    checks++;
    if (pc !== 32'h204) begin
      errors++;
      $display("FAIL beq not taken pc: got %h want 204", pc);
    end
    run_instr({6'h02, 26'h10}, 0, 1'b0, "j_to_40");
    run_instr({6'h05, 5'd3, 5'd4, 16'h0003}, 0, 1'b0, "bne");
    checks++;
    if (pc !== 32'h50) begin
      errors++;
      $display("FAIL bne taken pc: got %h want 50", pc);
    end
  endtask

  task automatic test_illegal;
    run_instr({6'h3F, 26'h123_4567}, 0, 1'b0, "illegal_op");
    run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h00}, 2, 1'b0, "illegal_funct");
  endtask

  task automatic test_run_low;
    bit ok;
    wait_fetch_req("run_low", ok);
    run = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (fetch_req !== 1'b0 || pc !== m_pc) begin
      errors++;
      $display("FAIL run low withdraw: got req=%b pc=%h want 0/%h", fetch_req, pc, m_pc);
    end
    fetch_ack = 1'b1;
    fetch_data = 32'h0022_1820;
    repeat (3) @(negedge CLK);
    checks++;
    if (fetch_req !== 1'b0 || pc !== m_pc || retired !== m_retired || regWrite !== 1'b0) begin
      errors++;
      $display("FAIL stray ack: got req=%b pc=%h ret=%0d rw=%b want 0/%h/%0d/0",
               fetch_req, pc, retired, regWrite, m_pc, m_retired);
    end
    fetch_ack = 1'b0;
    run = 1'b1;
    @(negedge CLK);
    checks++;
    if (fetch_req !== 1'b1 || pc !== m_pc) begin
      errors++;
      $display("FAIL run resume: got req=%b pc=%h want 1/%h", fetch_req, pc, m_pc);
    end
  endtask

  task automatic test_random;
    logic [5:0] r_funct [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] bad_ops [4] = '{6'h3F, 6'h01, 6'h10, 6'h20};
    logic [31:0] ins;
    for (int i = 0; i < 60; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 8))
        0, 1: ins = {6'h00, ins[25:6], r_funct[$urandom_range(0, 4)]};
        2:    ins[31:26] = 6'h23;
        3:    ins[31:26] = 6'h2B;
        4:    ins[31:26] = 6'h08;
        5:    ins[31:26] = 6'h04;
        6:    ins[31:26] = 6'h05;
        7:    ins[31:26] = 6'h02;
        default: ins[31:26] = bad_ops[$urandom_range(0, 3)];
      endcase
      run_instr(ins, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_wb;
    bit ok;
    int n;
    wait_fetch_req("reset_wb", ok);
    fetch_ack = 1'b1;
    fetch_data = 32'h0022_1820;
    @(negedge CLK);
    fetch_ack = 1'b0;
    n = 0;
    while (regWrite !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (regWrite !== 1'b1) begin
      errors++;
      $display("FAIL reset_wb reach WB: got regWrite=%b want 1", regWrite);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (regWrite !== 1'b0 || pc !== 32'h100 || retired !== 32'h0 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb async: got rw=%b pc=%h ret=%0d req=%b want 0/100/0/0", regWrite, pc, retired, fetch_req);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    m_pc = 32'h100;
    m_retired = 32'h0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_sw();
    test_branch();
    test_illegal();
    test_run_low();
    test_random();
    test_reset_mid_wb();
    test_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control sequencer for the single-cycle MIPS datapath (register file, sign extender, ALU, data memory).
- Owns the PC and fetches instructions over a request/acknowledge handshake.
- Latches each instruction into an instruction register (IR) and decodes it.
- Steps the datapath through EXEC/MEM/WB/BRANCH states by driving its registered control inputs; uses the datapath's registered `is_Zero` to resolve branches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- run  in  1  1 = fetch next instruction; 0 = hold in FETCH with no request.
- fetch_req  out  1  instruction request to instruction memory.
- pc  out  32  fetch address; valid while fetch_req = 1.
- fetch_ack  in  1  instruction on fetch_data accepted this cycle.
- fetch_data  in  32  instruction word.
- INST  out  32  IR contents, wired to the datapath INST input.
- regDst, regWrite, ALUSrc, memWrite, memRead, memtoReg  out  1 each  datapath controls.
- ALUcontrol  out  4  ALU operation.
- is_Zero  in  1  datapath zero flag, registered inside the datapath.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- retired  out  32  count of completed instructions.

## Operation
States: FETCH, DECODE, EXEC, MEM, WB, BRANCH.

**FETCH**
- fetch_req = run.
- On fetch_ack with fetch_req = 1:
  - IR <= fetch_data.
  - pc_plus4 <= pc + 4 (mod 2^32).
  - Go to DECODE.

**DECODE** (on IR[31:26]; funct = IR[5:0]):
- R-type, opcode 0x00; funct add 0x20 / sub 0x22 / and 0x24 / or 0x25 / slt 0x2A:
  - ALUcontrol = 0010 / 0110 / 0000 / 0001 / 0111.
  - regDst = 1, ALUSrc = 0, memtoReg = 0.
- lw 0x23, sw 0x2B, addi 0x08: ALUcontrol = 0010, ALUSrc = 1, regDst = 0; memtoReg = 1 for lw, 0 otherwise.
- beq 0x04, bne 0x05: ALUcontrol = 0110, ALUSrc = 0.
- All of the above go to EXEC.
- j 0x02: pc <= {pc_plus4[31:28], IR[25:0], 2'b00}; retired += 1; go to FETCH.
- Anything else (including an unknown funct):
  - illegal pulses for one cycle.
  - pc <= pc_plus4; retired += 1 (treated as NOP); go to FETCH.

**EXEC**
- One cycle; ALU settles; no write strobes.
- Next state: lw/sw → MEM; R-type/addi → WB; beq/bne → BRANCH.

**MEM**
- lw: memRead = 1; go to WB.
- sw: memWrite = 1 for exactly this cycle; pc <= pc_plus4; retired += 1; go to FETCH.

**WB**
- regWrite = 1 for exactly this cycle; memRead stays 1 for lw.
- pc <= pc_plus4; retired += 1; go to FETCH.

**BRANCH**
- is_Zero now reflects the EXEC-cycle subtract.
- taken = is_Zero (beq) or !is_Zero (bne).
- pc <= taken ? pc_plus4 + {{14{IR[15]}}, IR[15:0], 2'b00} : pc_plus4 (32-bit add, wraps).
- retired += 1; go to FETCH.

**Output holding rules**
- ALUcontrol, ALUSrc, regDst and memtoReg are registered in DECODE and held until the next DECODE.
- regWrite, memWrite and memRead are 0 outside the states listed above.

## Timing
- Reset (asynchronous):
  - State = FETCH, pc = RESET_PC, IR = 0, pc_plus4 = 0, retired = 0.
  - All control outputs = 0; fetch_req = 0 until the first edge after reset release.
- All outputs are registered. fetch_req is state-derived, qualified by run.
- Minimum cycles per instruction, with fetch_ack in the first FETCH cycle: j 2; R-type/addi 4; sw 4; beq/bne 4; lw 5.
- Handshake:
  - pc and fetch_req stay stable until fetch_ack.
  - fetch_ack while fetch_req = 0 is ignored.
  - run dropping while fetch_req = 1 withdraws the request; pc is unchanged.
- The register-file write (WB) and memory write (MEM) each occur on the single edge ending that state, so each happens exactly once per instruction.
- The branch uses is_Zero in BRANCH, never in EXEC, because the datapath registers is_Zero one edge late.
- retired wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-instruction: the current write strobe is dropped immediately and there is no partial pc update.

## Test plan
- Reset with RESET_PC = 0x100, run = 1 → fetch_req = 1, pc = 0x100; add $3,$1,$2 acked → regWrite high exactly once, in cycle 4; pc = 0x104; retired = 1.
- lw then sw with fetch_ack delayed 3 cycles → lw: memRead high 2 cycles, memtoReg = 1, regWrite 1 cycle, 8 cycles total; sw: memWrite 1 cycle, regWrite never asserted.
- beq with equal registers at pc 0x200, imm = 0xFFFF → pc = 0x200; same instruction with unequal registers → pc = 0x204.
- bne with imm = 0x0003 and unequal registers at pc 0x40 → pc = 0x50.
- j 0x0000010 at pc 0x3000_0000 → pc = 0x3000_0040 after 2 cycles, no write strobes.
- Opcode 0x3F → illegal pulses once, pc += 4, no strobes; run = 0 → fetch_req stays low, pc frozen; RST_N low during WB → regWrite drops at once, pc = RESET_PC.
